alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor of the 32-bit combinational ALU (a, b, op -> result, c/n/z/v).
- Generalised data width; op field widened to 4 bits.
- Adds shift ops and a multi-cycle shift-add multiply.
- Operands enter and results leave through valid/ready handshakes; result and flags are held in registers until consumed.
- Sits between an operand source (register file or stimulus FSM) and a result sink.

Parameters:
- WIDTH, 32, datapath width in bits (>= 4).
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, only b[SHW-1:0] is used.
- op  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  sink accepts result.
- result  out  WIDTH  registered result.
- c  out  1  carry flag.
- n  out  1  negative flag.
- z  out  1  zero flag.
- v  out  1  overflow flag.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; result=0; c=n=z=v=0; out_valid=0; in_ready=1.
  - Internal multiply registers and counter cleared.
  - Reset mid-multiply aborts the operation; no result is emitted.
- Op codes:
  - 0000 ~a
  - 0001 ~b
  - 0010 a&b
  - 0011 a|b
  - 0100 a^b
  - 0101 ~(a^b)
  - 0110 a+b
  - 0111 a-b (a+~b+1)
  - 1000 a<<b[SHW-1:0]
  - 1001 logical a>>sh
  - 1010 arithmetic a>>>sh
  - 1011 MUL: low WIDTH bits of a*b, unsigned
  - 1100-1111 reserved: result=0, z=1, other flags 0, single-cycle.
- Flags:
  - n = result[WIDTH-1].
  - z = (result==0).
  - c, v meaningful only for 0110/0111; 0 for all other ops.
  - ADD: c = carry out; v = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: c = carry out of a+~b+1 (1 means no borrow); v = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
- Handshake: a transfer occurs on a rising edge with valid && ready.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1, out_valid=0.
    - Single-cycle op accepted -> result/flags registered on the same edge -> DONE. Latency: out_valid high 1 cycle after acceptance.
    - MUL accepted -> latch a, b; clear accumulator; counter=0 -> MUL.
  - MUL: in_ready=0, out_valid=0.
    - Each cycle: if multiplier LSB=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
    - After WIDTH iterations -> DONE with result=accumulator and flags per rules above.
    - Total latency WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1.
    - result and flags stay stable while out_ready=0.
    - in_ready = out_ready, so a new bundle can be accepted on the same edge the result is consumed.
    - out_ready=1 && in_valid=1 -> back-to-back transfer; next state per new op (DONE or MUL); no bubble.
    - out_ready=1 && in_valid=0 -> IDLE, out_valid=0.
- Inputs a, b, op are ignored whenever no transfer occurs.
- Registered result/flags persist after consumption (not cleared) until the next completion.
- Shift by 0 returns a. No flags are derived from shifted-out bits.

Test Plan (WIDTH=32):
- Reset then idle: reset_n=0 at t=3 mid-cycle -> all outputs 0 immediately, in_ready=1. Release; no in_valid -> out_valid stays 0.
- ADD overflow: a=7FFFFFFF, b=00000001, op=0110, out_ready=1 -> next cycle out_valid=1, result=80000000, cnzv=0101. ADD carry: a=FFFFFFFF, b=00000001 -> result=0, cnzv=1010.
- SUB / back-to-back: pipelined bundles on consecutive cycles:
  - a=5, b=5, op=0111 -> result=0, cnzv=1010.
  - then a=0, b=1, op=0111 -> FFFFFFFF, cnzv=0100.
  - Both on consecutive cycles, with no bubble while out_ready=1.
- Shifts: a=80000001, b=4, op=1010 -> F8000000, n=1. Same with op=1001 -> 08000000. op=1000 -> 00000010.
- MUL latency/backpressure: a=0000FFFF, b=00010001, op=1011 -> in_ready=0 for 32 cycles; out_valid at cycle 33; result=FFFFFFFF, n=1. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Assert reset_n=0 during a second MUL -> no out_valid afterwards.
- Logic/reserved: a=F0F0F0F0, b=0F0F0F0F:
  - op=0010 -> 0, z=1.
  - op=0101 -> 0, z=1.
  - op=0000 -> 0F0F0F0F.
  - op=1111 -> 0, cnzv=0010.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift ops plus a WIDTH-iteration shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);

    localparam logic [3:0]     OpMul    = 4'b1011;
    localparam logic [SHW:0]   LastIter = (SHW + 1)'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHW:0]       cnt_q;

    logic               accept;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    always_comb begin
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StDone:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    assign sh      = b[SHW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'b0000: alu_res = ~a;
            4'b0001: alu_res = ~b;
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a ^ b;
            4'b0101: alu_res = ~(a ^ b);
            4'b0110: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1000: alu_res = a << sh;
            4'b1001: alu_res = a >> sh;
            4'b1010: alu_res = $signed(a) >>> sh;
            default: alu_res = '0; // reserved codes; MUL never uses this path
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            result   <= '0;
            c        <= 1'b0;
            n        <= 1'b0;
            z        <= 1'b0;
            v        <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (op == OpMul) begin
                mcand_q  <= a;
                mplier_q <= b;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= StMul;
            end else begin
                result  <= alu_res;
                c       <= alu_c;
                n       <= alu_res[WIDTH-1];
                z       <= (alu_res == '0);
                v       <= alu_v;
                state_q <= StDone;
            end
        end else if (state_q == StMul) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            // Final iteration publishes straight from the adder output
            if (cnt_q == LastIter) begin
                result  <= acc_next;
                c       <= 1'b0;
                n       <= acc_next[WIDTH-1];
                z       <= (acc_next == '0);
                v       <= 1'b0;
                state_q <= StDone;
            end
        end else if (state_q == StDone && out_ready) begin
            state_q <= StIdle;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c;
    logic         n;
    logic         z;
    logic         v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHW(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c         (c),
        .n         (n),
        .z         (z),
        .v         (v)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bundle, lets it transfer, checks the registered outcome.
    task automatic apply(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [3:0] opi, input logic [W-1:0] er, input logic [3:0] ef);
        in_valid = 1'b1;
        a        = ai;
        b        = bi;
        op       = opi;
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, 64'(result), 64'(er));
        check({tag, "_cnzv"}, 64'({c, n, z, v}), 64'(ef));
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        op       = 4'b0110;
        tick();
    endtask

    initial begin
        int busy;
        int bad;
        logic [W-1:0] held;

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;

        // Asynchronous reset mid-cycle
        #3 reset_n = 1'b0;
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_cnzv", 64'({c, n, z, v}), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("idle_no_valid", 64'(bad), 64'd0);

        out_ready = 1'b1;
        apply("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0110, 32'h8000_0000, 4'b0101);
        go_idle();
        check("idle_after_consume", 64'(out_valid), 64'd0);
        apply("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0110, 32'h0000_0000, 4'b1010);
        go_idle();

        // Back-to-back subtractions with out_ready held high
        apply("sub_eq", 32'd5, 32'd5, 4'b0111, 32'h0000_0000, 4'b1010);
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        apply("sub_borrow", 32'd0, 32'd1, 4'b0111, 32'hFFFF_FFFF, 4'b0100);
        go_idle();

        apply("sra", 32'h8000_0001, 32'd4, 4'b1010, 32'hF800_0000, 4'b0100);
        apply("srl", 32'h8000_0001, 32'd4, 4'b1001, 32'h0800_0000, 4'b0000);
        apply("sll", 32'h8000_0001, 32'd4, 4'b1000, 32'h0000_0010, 4'b0000);
        apply("shift0", 32'h8000_0001, 32'd0, 4'b1001, 32'h8000_0001, 4'b0100);
        go_idle();

        // Multiply: latency, busy in_ready, backpressure
        in_valid = 1'b1;
        a        = 32'h0000_FFFF;
        b        = 32'h0001_0001;
        op       = 4'b1011;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h1111_1111;
        b         = 32'h2222_2222;
        busy      = 0;
        bad       = 0;
        while (!out_valid && busy < 100) begin
            if (in_ready !== 1'b0) bad++;
            busy++;
            tick();
        end
        check("mul_latency", 64'(busy), 64'd32);
        check("mul_busy_ready", 64'(bad), 64'd0);
        check("mul_res", 64'(result), 64'hFFFF_FFFF);
        check("mul_cnzv", 64'({c, n, z, v}), 64'b0100);

        // New bundle offered while stalled must be ignored
        held     = result;
        in_valid = 1'b1;
        op       = 4'b0110;
        bad      = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("mul_hold", 64'(bad), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mul_consumed", 64'(out_valid), 64'd0);
        check("persist_res", 64'(result), 64'hFFFF_FFFF);

        // Reset aborts an in-flight multiply
        in_valid = 1'b1;
        a        = 32'd3;
        b        = 32'd7;
        op       = 4'b1011;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_result", 64'(result), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        bad     = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("abort_no_valid", 64'(bad), 64'd0);

        apply("and", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0010, 32'h0000_0000, 4'b0010);
        apply("xnor", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0101, 32'h0000_0000, 4'b0010);
        apply("nota", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0000, 32'h0F0F_0F0F, 4'b0000);
        apply("or", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0011, 32'hFFFF_FFFF, 4'b0100);
        apply("rsvd", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1111, 32'h0000_0000, 4'b0010);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
